// File: rtl/pattern_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pattern_tx_pkg
// Description : Shared state encoding, idle level and width helpers for the
//               serial test-pattern transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package pattern_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } tx_state_t;

    localparam logic c_idle_level_default = 1'b0;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Counter width that never collapses to zero bits for counts of 1.
    function automatic int cnt_width(input int count);
        return (count > 1) ? clog2(count) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_tx_gen_bit_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : bit_tick_gen
// Description : Bit-period divider; ticks on the last clock of every DIV-clock
//               bit period, held at phase zero while restart is high.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_tick_gen
    import pattern_tx_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int                 c_cnt_w = cnt_width(DIV);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIV - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_one;
        end
    end

    assign tick = (r_cnt == c_last) && !restart;

endmodule
`default_nettype wire

// File: rtl/pattern_tx_gen.sv
`default_nettype none
// ============================================================================
// Module      : pattern_tx_gen
// Description : Serial test-pattern transmitter: writable pattern memory,
//               MSB-first serialiser with one-shot and continuous bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_tx_gen
    import pattern_tx_pkg::*;
#(
    parameter int   DATA_W     = 8,
    parameter int   DEPTH      = 16,
    parameter int   BIT_DIV    = 4,
    parameter int   GAP_BITS   = 2,
    parameter logic IDLE_LEVEL = c_idle_level_default
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       send_en,
    input  logic                       mode,
    input  logic [7:0]                 rep_cnt,
    input  logic [$clog2(DEPTH+1)-1:0] len,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       ser_out,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       burst_done,
    output logic                       wr_rej,
    output logic [$clog2(DEPTH)-1:0]   word_idx
);

    localparam int c_idx_w = $clog2(DEPTH);
    localparam int c_len_w = $clog2(DEPTH + 1);
    localparam int c_bit_w = cnt_width(DATA_W);
    // GAP_BITS is expected to be at least 1.
    localparam int c_gap_w = cnt_width(GAP_BITS);

    localparam logic [c_len_w-1:0] c_depth_len = c_len_w'(DEPTH);
    localparam logic [c_len_w-1:0] c_len_one   = c_len_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_one   = c_idx_w'(1);
    localparam logic [c_bit_w-1:0] c_bit_last  = c_bit_w'(DATA_W - 1);
    localparam logic [c_bit_w-1:0] c_bit_one   = c_bit_w'(1);
    localparam logic [c_gap_w-1:0] c_gap_last  = c_gap_w'(GAP_BITS - 1);
    localparam logic [c_gap_w-1:0] c_gap_one   = c_gap_w'(1);

    tx_state_t           r_state;
    tx_state_t           w_state_n;
    logic                r_send_en_q;
    logic [c_len_w-1:0]  r_len;
    logic [c_len_w-1:0]  w_len_n;
    logic                r_mode;
    logic                w_mode_n;
    logic [7:0]          r_frames_left;
    logic [7:0]          w_frames_left_n;
    logic [DATA_W-1:0]   r_shreg;
    logic [DATA_W-1:0]   w_shreg_n;
    logic [c_bit_w-1:0]  r_bit_cnt;
    logic [c_bit_w-1:0]  w_bit_cnt_n;
    logic [c_gap_w-1:0]  r_gap_cnt;
    logic [c_gap_w-1:0]  w_gap_cnt_n;
    logic [c_idx_w-1:0]  r_word_idx;
    logic [c_idx_w-1:0]  w_word_idx_n;
    logic                r_ser;
    logic                w_ser_n;
    logic                r_busy;
    logic                w_busy_n;
    logic                r_frame_done;
    logic                w_frame_done_n;
    logic                r_burst_done;
    logic                w_burst_done_n;
    logic                r_wr_rej;
    logic                w_wr_rej_n;

    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_edge;
    logic                w_len_ok;
    logic                w_start;
    logic                w_wr_ok;
    logic                w_tick;
    logic                w_restart;
    logic                w_last_word;
    logic                w_more_frames;
    logic [DATA_W-1:0]   w_rd_cur;
    logic [DATA_W-1:0]   w_rd_next;
    logic [DATA_W-1:0]   w_rd_first;

    assign w_edge    = send_en & ~r_send_en_q;
    assign w_len_ok  = (len != '0) && (len <= c_depth_len);
    assign w_start   = (r_state == ST_IDLE) && w_edge && w_len_ok;
    assign w_wr_ok   = !r_busy && !w_start;
    assign w_restart = (r_state == ST_IDLE) || (r_state == ST_LOAD);

    assign w_last_word   = (c_len_w'(r_word_idx) == (r_len - c_len_one));
    assign w_more_frames = r_mode ? send_en : (r_frames_left != 8'd0);

    assign w_rd_cur   = r_mem[r_word_idx];
    assign w_rd_next  = r_mem[r_word_idx + c_idx_one];
    assign w_rd_first = r_mem[0];

    bit_tick_gen #(
        .DIV     (BIT_DIV)
    ) u_bit_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // Pattern memory: no reset, writes only while the shifter is idle.
    always_ff @(posedge clk) begin
        if (wr_en && w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        w_state_n       = r_state;
        w_len_n         = r_len;
        w_mode_n        = r_mode;
        w_frames_left_n = r_frames_left;
        w_shreg_n       = r_shreg;
        w_bit_cnt_n     = r_bit_cnt;
        w_gap_cnt_n     = r_gap_cnt;
        w_word_idx_n    = r_word_idx;
        w_busy_n        = r_busy;
        w_frame_done_n  = 1'b0;
        w_burst_done_n  = 1'b0;
        w_wr_rej_n      = wr_en && !w_wr_ok;
        w_ser_n         = (r_state == ST_SHIFT) ? r_shreg[DATA_W-1] : IDLE_LEVEL;

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_n       = ST_LOAD;
                    w_len_n         = len;
                    w_mode_n        = mode;
                    w_frames_left_n = rep_cnt;
                    w_word_idx_n    = '0;
                    w_busy_n        = 1'b1;
                end
            end

            ST_LOAD: begin
                w_shreg_n   = w_rd_cur;
                w_bit_cnt_n = '0;
                w_state_n   = ST_SHIFT;
            end

            ST_SHIFT: begin
                if (w_tick) begin
                    if (r_bit_cnt == c_bit_last) begin
                        w_bit_cnt_n = '0;
                        if (w_last_word) begin
                            w_state_n    = ST_GAP;
                            w_gap_cnt_n  = '0;
                            w_word_idx_n = '0;
                        end else begin
                            // Preload during the last bit so words run back-to-back.
                            w_word_idx_n = r_word_idx + c_idx_one;
                            w_shreg_n    = w_rd_next;
                        end
                    end else begin
                        w_bit_cnt_n = r_bit_cnt + c_bit_one;
                        w_shreg_n   = r_shreg << 1;
                    end
                end
            end

            ST_GAP: begin
                if (w_tick) begin
                    if (r_gap_cnt == c_gap_last) begin
                        w_frame_done_n = 1'b1;
                        if (w_more_frames) begin
                            if (!r_mode) begin
                                w_frames_left_n = r_frames_left - 8'd1;
                            end
                            // Next frame's first word loads here, not in LOAD.
                            w_state_n    = ST_SHIFT;
                            w_shreg_n    = w_rd_first;
                            w_bit_cnt_n  = '0;
                            w_word_idx_n = '0;
                        end else begin
                            w_state_n      = ST_IDLE;
                            w_busy_n       = 1'b0;
                            w_burst_done_n = 1'b1;
                        end
                    end else begin
                        w_gap_cnt_n = r_gap_cnt + c_gap_one;
                    end
                end
            end

            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_send_en_q   <= 1'b0;
            r_len         <= '0;
            r_mode        <= 1'b0;
            r_frames_left <= 8'd0;
            r_shreg       <= '0;
            r_bit_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_word_idx    <= '0;
            r_ser         <= IDLE_LEVEL;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_burst_done  <= 1'b0;
            r_wr_rej      <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_send_en_q   <= send_en;
            r_len         <= w_len_n;
            r_mode        <= w_mode_n;
            r_frames_left <= w_frames_left_n;
            r_shreg       <= w_shreg_n;
            r_bit_cnt     <= w_bit_cnt_n;
            r_gap_cnt     <= w_gap_cnt_n;
            r_word_idx    <= w_word_idx_n;
            r_ser         <= w_ser_n;
            r_busy        <= w_busy_n;
            r_frame_done  <= w_frame_done_n;
            r_burst_done  <= w_burst_done_n;
            r_wr_rej      <= w_wr_rej_n;
        end
    end

    assign ser_out    = r_ser;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign burst_done = r_burst_done;
    assign wr_rej     = r_wr_rej;
    assign word_idx   = r_word_idx;

endmodule
`default_nettype wire
